n101_sram_icb_arbt: RTL and testbench
=====================================

# n101_sram_icb_arbt

Two-to-one ICB arbiter that shares one SRAM ICB controller port between two requesters, typically the instruction-fetch path (port 0) and the load/store path (port 1) of a TCM. It sits directly in front of the SRAM ICB controller. It grants commands round-robin and records the source of every accepted command in an in-order outstanding FIFO. Responses are routed back to the originating port using that FIFO.

## Interface
- DW, 32, data width
- MW, 4, write-mask width (DW/8)
- AW, 32, address width
- USR_W, 3, user sideband width, passed through unmodified
- OUTS_DP, 2, maximum outstanding commands (1..4)
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i0_icb_cmd_valid / i0_icb_cmd_ready  input/output  1  port 0 command handshake
- i0_icb_cmd_read  input  1  port 0 read (1) / write (0)
- i0_icb_cmd_addr  input  AW  port 0 address
- i0_icb_cmd_wdata  input  DW  port 0 write data
- i0_icb_cmd_wmask  input  MW  port 0 byte mask
- i0_icb_cmd_usr  input  USR_W  port 0 user bits
- i0_icb_rsp_valid / i0_icb_rsp_ready  output/input  1  port 0 response handshake
- i0_icb_rsp_rdata  output  DW  port 0 read data
- i0_icb_rsp_usr  output  USR_W  port 0 user bits
- i1_icb_*: identical set for port 1
- o_icb_cmd_valid / o_icb_cmd_ready  output/input  1  shared command handshake
- o_icb_cmd_read, o_icb_cmd_addr, o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_cmd_usr  output  1/AW/DW/MW/USR_W  muxed command fields
- o_icb_rsp_valid / o_icb_rsp_ready  input/output  1  shared response handshake
- o_icb_rsp_rdata, o_icb_rsp_usr  input  DW/USR_W  shared response fields
- arbt_active  output  1  any valid present or outstanding count nonzero (clock-gating hint)

## Operation
- State: `rr_ptr` (1 bit, port holding priority, reset 0), outstanding FIFO of 1-bit source IDs (OUTS_DP entries), `outs_cnt` (0..OUTS_DP, reset 0), read/write pointers (reset 0).
- Full: outs_cnt == OUTS_DP. Empty: outs_cnt == 0.
- Arbitration (combinational): if not full, grant goes to the single requesting port. If both ports request, grant goes to the port indicated by rr_ptr. If full, there is no grant.
- o_icb_cmd_valid = (i0 valid | i1 valid) & ~full. Command fields are muxed from the granted port, or from port 0 when neither port is granted.
- iN_icb_cmd_ready = grantN & o_icb_cmd_ready. The non-granted port sees ready=0.
- On an o_icb_cmd handshake:
  - Push the granted ID into the FIFO.
  - rr_ptr <= ~granted ID, so the other port gets priority next time.
  - rr_ptr does not change on cycles without a handshake.
- Response routing uses head ID h.
  - ih_icb_rsp_valid = o_icb_rsp_valid & ~empty; the other port's rsp_valid = 0.
  - o_icb_rsp_ready = ih_icb_rsp_ready & ~empty.
  - rdata and usr are broadcast to both ports.
- On an o_icb_rsp handshake, pop the FIFO.
- Simultaneous push and pop: outs_cnt unchanged, both pointers advance.
- Full blocks a new command even if a pop happens in the same cycle. No combinational path from rsp_ready to cmd_ready.
- o_icb_rsp_valid while empty is a protocol violation. It is not forwarded (o_icb_rsp_ready = 0), and the bench flags it with an assertion.
- Pointers wrap modulo OUTS_DP.
- Reset mid-transaction: FIFO, count and rr_ptr clear asynchronously. In-flight responses are lost; the system resets downstream together with this block.

## Timing
- Zero-cycle command path: valid to ready and fields are combinational through the arbiter. One register stage (FIFO/rr_ptr) updates on the clock edge.
- Zero-cycle response path: combinational.
- Reset values of outputs:
  - all valid/ready outputs 0 unless driven combinationally by inputs;
  - with idle inputs, o_icb_cmd_valid = 0, iN_rsp_valid = 0, arbt_active = 0.
- Throughput: one command per cycle while not full. With both ports saturated, grants alternate 0,1,0,1.
- A grant is combinational within the cycle. A requester that drops valid before ready has no effect on state; ICB rules require valid to stay stable until the handshake.

## Test plan
- Reset then a single port-0 read at addr 0x100 with o_cmd_ready=1 and a response one cycle later with rdata 0xDEADBEEF. Required: i0 receives rsp_valid and 0xDEADBEEF; i1 sees no rsp_valid; outs_cnt returns to 0.
- Both ports held valid for 6 cycles, o_cmd_ready=1, responses returned immediately. Required: grant order 0,1,0,1,0,1; each response lands on the issuing port.
- OUTS_DP=2, o_rsp_valid held 0. Required: two commands accepted (i0, then i1); third request sees cmd_ready=0 and o_cmd_valid=0. Releasing one response re-enables issue on the following cycle.
- Port-0 response with i0_rsp_ready=0 for 3 cycles. Required: o_icb_rsp_ready=0 for those cycles, FIFO head unchanged, and no response is delivered to i1 even while i1 has outstanding commands.
- Same-cycle push and pop at outs_cnt=1. Required: count stays 1 and ordering is preserved across pointer wrap over 10 mixed transactions.
- Assert rst_n low with 2 outstanding. Required: arbt_active=0 and outs_cnt=0 immediately; rr_ptr=0, so the first grant after reset goes to port 0.

Source files
------------

// File: rtl/n101_sram_icb_arbt.sv
// n101_sram_icb_arbt: two-to-one ICB arbiter in front of the SRAM ICB controller.
// Commands are granted round-robin. An in-order FIFO of source IDs routes
// each response back to the port that issued the command.
module n101_sram_icb_arbt #(
  parameter int unsigned DW      = 32,
  parameter int unsigned MW      = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned USR_W   = 3,
  parameter int unsigned OUTS_DP = 2
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             i0_icb_cmd_valid,
  output logic             i0_icb_cmd_ready,
  input  logic             i0_icb_cmd_read,
  input  logic [AW-1:0]    i0_icb_cmd_addr,
  input  logic [DW-1:0]    i0_icb_cmd_wdata,
  input  logic [MW-1:0]    i0_icb_cmd_wmask,
  input  logic [USR_W-1:0] i0_icb_cmd_usr,
  output logic             i0_icb_rsp_valid,
  input  logic             i0_icb_rsp_ready,
  output logic [DW-1:0]    i0_icb_rsp_rdata,
  output logic [USR_W-1:0] i0_icb_rsp_usr,

  input  logic             i1_icb_cmd_valid,
  output logic             i1_icb_cmd_ready,
  input  logic             i1_icb_cmd_read,
  input  logic [AW-1:0]    i1_icb_cmd_addr,
  input  logic [DW-1:0]    i1_icb_cmd_wdata,
  input  logic [MW-1:0]    i1_icb_cmd_wmask,
  input  logic [USR_W-1:0] i1_icb_cmd_usr,
  output logic             i1_icb_rsp_valid,
  input  logic             i1_icb_rsp_ready,
  output logic [DW-1:0]    i1_icb_rsp_rdata,
  output logic [USR_W-1:0] i1_icb_rsp_usr,

  output logic             o_icb_cmd_valid,
  input  logic             o_icb_cmd_ready,
  output logic             o_icb_cmd_read,
  output logic [AW-1:0]    o_icb_cmd_addr,
  output logic [DW-1:0]    o_icb_cmd_wdata,
  output logic [MW-1:0]    o_icb_cmd_wmask,
  output logic [USR_W-1:0] o_icb_cmd_usr,
  input  logic             o_icb_rsp_valid,
  output logic             o_icb_rsp_ready,
  input  logic [DW-1:0]    o_icb_rsp_rdata,
  input  logic [USR_W-1:0] o_icb_rsp_usr,

  output logic             arbt_active
);

  localparam int unsigned PTR_W  = (OUTS_DP > 1) ? $clog2(OUTS_DP) : 1;
  localparam int unsigned CNT_W  = $clog2(OUTS_DP + 1);
  localparam int unsigned FIFO_N = 1 << PTR_W;

  // State: priority pointer, source-ID FIFO, pointers and occupancy
  logic              r_rr_ptr;
  logic [FIFO_N-1:0] r_fifo;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_outs_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_push;
  logic             w_pop;
  logic             w_head;
  logic [PTR_W-1:0] w_wptr_nxt;
  logic [PTR_W-1:0] w_rptr_nxt;

  assign w_full  = (r_outs_cnt == CNT_W'(OUTS_DP));
  assign w_empty = (r_outs_cnt == CNT_W'(0));
  assign w_head  = r_fifo[r_rptr];

  // Round-robin grant; a sole requester wins regardless of priority, none when full
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!w_full) begin
      w_gnt0 = i0_icb_cmd_valid & (~i1_icb_cmd_valid | ~r_rr_ptr);
      w_gnt1 = i1_icb_cmd_valid & (~i0_icb_cmd_valid |  r_rr_ptr);
    end
  end

  // Shared command channel: fields follow the grant, port 0 by default
  always_comb begin
    o_icb_cmd_valid  = (i0_icb_cmd_valid | i1_icb_cmd_valid) & ~w_full;
    o_icb_cmd_read   = w_gnt1 ? i1_icb_cmd_read  : i0_icb_cmd_read;
    o_icb_cmd_addr   = w_gnt1 ? i1_icb_cmd_addr  : i0_icb_cmd_addr;
    o_icb_cmd_wdata  = w_gnt1 ? i1_icb_cmd_wdata : i0_icb_cmd_wdata;
    o_icb_cmd_wmask  = w_gnt1 ? i1_icb_cmd_wmask : i0_icb_cmd_wmask;
    o_icb_cmd_usr    = w_gnt1 ? i1_icb_cmd_usr   : i0_icb_cmd_usr;
    i0_icb_cmd_ready = w_gnt0 & o_icb_cmd_ready;
    i1_icb_cmd_ready = w_gnt1 & o_icb_cmd_ready;
  end

  // Response routing by FIFO head; a response with nothing outstanding is dropped
  always_comb begin
    i0_icb_rsp_valid = o_icb_rsp_valid & ~w_empty & ~w_head;
    i1_icb_rsp_valid = o_icb_rsp_valid & ~w_empty &  w_head;
    o_icb_rsp_ready  = ~w_empty & (w_head ? i1_icb_rsp_ready : i0_icb_rsp_ready);
    i0_icb_rsp_rdata = o_icb_rsp_rdata;
    i1_icb_rsp_rdata = o_icb_rsp_rdata;
    i0_icb_rsp_usr   = o_icb_rsp_usr;
    i1_icb_rsp_usr   = o_icb_rsp_usr;
  end

  assign arbt_active = i0_icb_cmd_valid | i1_icb_cmd_valid | o_icb_rsp_valid | ~w_empty;

  assign w_push = o_icb_cmd_valid & o_icb_cmd_ready;
  assign w_pop  = o_icb_rsp_valid & o_icb_rsp_ready;

  // Pointers wrap modulo the FIFO depth, which need not be a power of two
  assign w_wptr_nxt = (r_wptr == PTR_W'(OUTS_DP - 1)) ? '0 : r_wptr + PTR_W'(1);
  assign w_rptr_nxt = (r_rptr == PTR_W'(OUTS_DP - 1)) ? '0 : r_rptr + PTR_W'(1);

  // FIFO, occupancy and priority update on handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= 1'b0;
      r_fifo     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_outs_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_gnt1;
        r_wptr         <= w_wptr_nxt;
        r_rr_ptr       <= ~w_gnt1;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_nxt;
      end
      if (w_push && !w_pop) begin
        r_outs_cnt <= r_outs_cnt + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_outs_cnt <= r_outs_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_n101_sram_icb_arbt.sv
// Directed self-checking bench for n101_sram_icb_arbt (OUTS_DP = 2).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_n101_sram_icb_arbt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        i0_cmd_valid, i0_cmd_ready, i0_cmd_read;
  logic [31:0] i0_cmd_addr, i0_cmd_wdata;
  logic [3:0]  i0_cmd_wmask;
  logic [2:0]  i0_cmd_usr;
  logic        i0_rsp_valid, i0_rsp_ready;
  logic [31:0] i0_rsp_rdata;
  logic [2:0]  i0_rsp_usr;

  logic        i1_cmd_valid, i1_cmd_ready, i1_cmd_read;
  logic [31:0] i1_cmd_addr, i1_cmd_wdata;
  logic [3:0]  i1_cmd_wmask;
  logic [2:0]  i1_cmd_usr;
  logic        i1_rsp_valid, i1_rsp_ready;
  logic [31:0] i1_rsp_rdata;
  logic [2:0]  i1_rsp_usr;

  logic        o_cmd_valid, o_cmd_ready, o_cmd_read;
  logic [31:0] o_cmd_addr, o_cmd_wdata;
  logic [3:0]  o_cmd_wmask;
  logic [2:0]  o_cmd_usr;
  logic        o_rsp_valid, o_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic [2:0]  o_rsp_usr;
  logic        arbt_active;

  int n_total = 0;
  int n_pass  = 0;
  int m_cnt   = 0;

  n101_sram_icb_arbt #(.DW(32), .MW(4), .AW(32), .USR_W(3), .OUTS_DP(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i0_icb_cmd_valid(i0_cmd_valid), .i0_icb_cmd_ready(i0_cmd_ready),
    .i0_icb_cmd_read(i0_cmd_read), .i0_icb_cmd_addr(i0_cmd_addr),
    .i0_icb_cmd_wdata(i0_cmd_wdata), .i0_icb_cmd_wmask(i0_cmd_wmask),
    .i0_icb_cmd_usr(i0_cmd_usr),
    .i0_icb_rsp_valid(i0_rsp_valid), .i0_icb_rsp_ready(i0_rsp_ready),
    .i0_icb_rsp_rdata(i0_rsp_rdata), .i0_icb_rsp_usr(i0_rsp_usr),
    .i1_icb_cmd_valid(i1_cmd_valid), .i1_icb_cmd_ready(i1_cmd_ready),
    .i1_icb_cmd_read(i1_cmd_read), .i1_icb_cmd_addr(i1_cmd_addr),
    .i1_icb_cmd_wdata(i1_cmd_wdata), .i1_icb_cmd_wmask(i1_cmd_wmask),
    .i1_icb_cmd_usr(i1_cmd_usr),
    .i1_icb_rsp_valid(i1_rsp_valid), .i1_icb_rsp_ready(i1_rsp_ready),
    .i1_icb_rsp_rdata(i1_rsp_rdata), .i1_icb_rsp_usr(i1_rsp_usr),
    .o_icb_cmd_valid(o_cmd_valid), .o_icb_cmd_ready(o_cmd_ready),
    .o_icb_cmd_read(o_cmd_read), .o_icb_cmd_addr(o_cmd_addr),
    .o_icb_cmd_wdata(o_cmd_wdata), .o_icb_cmd_wmask(o_cmd_wmask),
    .o_icb_cmd_usr(o_cmd_usr),
    .o_icb_rsp_valid(o_rsp_valid), .o_icb_rsp_ready(o_rsp_ready),
    .o_icb_rsp_rdata(o_rsp_rdata), .o_icb_rsp_usr(o_rsp_usr),
    .arbt_active(arbt_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stimulus-side outstanding count; a response driven with nothing outstanding is illegal
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
    end else begin
      if (o_rsp_valid) begin
        n_total++;
        assert (m_cnt != 0) begin
          n_pass++;
        end else begin
          $error("FAIL rsp_while_empty: observed count %0d expected nonzero", m_cnt);
        end
      end
      m_cnt <= m_cnt + ((o_cmd_valid && o_cmd_ready) ? 1 : 0)
                     - ((o_rsp_valid && o_rsp_ready) ? 1 : 0);
    end
  end

  task automatic idle();
    i0_cmd_valid = 0; i0_cmd_read = 0; i0_cmd_addr = 0; i0_cmd_wdata = 0;
    i0_cmd_wmask = 0; i0_cmd_usr = 0; i0_rsp_ready = 0;
    i1_cmd_valid = 0; i1_cmd_read = 0; i1_cmd_addr = 0; i1_cmd_wdata = 0;
    i1_cmd_wmask = 0; i1_cmd_usr = 0; i1_rsp_ready = 0;
    o_cmd_ready = 0; o_rsp_valid = 0; o_rsp_rdata = 0; o_rsp_usr = 0;
  endtask

  initial begin
    logic exp_g [6];
    logic pat [10];
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    pat   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    idle();
    #1;
    check("rst_cmd_valid", 32'(o_cmd_valid), 32'd0);
    check("rst_i0_rsp_valid", 32'(i0_rsp_valid), 32'd0);
    check("rst_i1_rsp_valid", 32'(i1_rsp_valid), 32'd0);
    check("rst_active", 32'(arbt_active), 32'd0);
    @(negedge clk) rst_n = 1;

    // Single port-0 read and its response
    @(negedge clk);
    i0_cmd_valid = 1; i0_cmd_read = 1; i0_cmd_addr = 32'h100;
    i0_cmd_usr = 3'd5; i0_cmd_wmask = 4'hF; o_cmd_ready = 1;
    #1;
    check("t1_cmd_valid", 32'(o_cmd_valid), 32'd1);
    check("t1_cmd_addr", o_cmd_addr, 32'h100);
    check("t1_cmd_read", 32'(o_cmd_read), 32'd1);
    check("t1_cmd_usr", 32'(o_cmd_usr), 32'd5);
    check("t1_i0_ready", 32'(i0_cmd_ready), 32'd1);
    check("t1_i1_ready", 32'(i1_cmd_ready), 32'd0);
    @(negedge clk);
    idle();
    o_rsp_valid = 1; o_rsp_rdata = 32'hDEADBEEF; i0_rsp_ready = 1;
    #1;
    check("t1_i0_rsp_valid", 32'(i0_rsp_valid), 32'd1);
    check("t1_i0_rdata", i0_rsp_rdata, 32'hDEADBEEF);
    check("t1_i1_rsp_valid", 32'(i1_rsp_valid), 32'd0);
    check("t1_o_rsp_ready", 32'(o_rsp_ready), 32'd1);
    @(negedge clk);
    idle();
    #1;
    check("t1_drained", 32'(arbt_active), 32'd0);

    // Fresh reset so priority starts at port 0
    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;

    // Both ports saturated, response returned the next cycle
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      idle();
      i0_cmd_valid = (k < 6); i0_cmd_addr = 32'h1000; i0_cmd_wdata = 32'h11111111;
      i1_cmd_valid = (k < 6); i1_cmd_addr = 32'h2000; i1_cmd_wdata = 32'h22222222;
      o_cmd_ready = 1; i0_rsp_ready = 1; i1_rsp_ready = 1;
      o_rsp_valid = (k >= 1); o_rsp_rdata = 32'hA0 + 32'(k);
      #1;
      if (k < 6) begin
        check($sformatf("t2_i0_ready_%0d", k), 32'(i0_cmd_ready), 32'(!exp_g[k]));
        check($sformatf("t2_i1_ready_%0d", k), 32'(i1_cmd_ready), 32'(exp_g[k]));
        check($sformatf("t2_addr_%0d", k), o_cmd_addr, exp_g[k] ? 32'h2000 : 32'h1000);
        check($sformatf("t2_wdata_%0d", k), o_cmd_wdata, exp_g[k] ? 32'h22222222 : 32'h11111111);
      end
      if (k >= 1) begin
        check($sformatf("t2_i0_rsp_%0d", k), 32'(i0_rsp_valid), 32'(!exp_g[k-1]));
        check($sformatf("t2_i1_rsp_%0d", k), 32'(i1_rsp_valid), 32'(exp_g[k-1]));
        check($sformatf("t2_rdata_%0d", k), exp_g[k-1] ? i1_rsp_rdata : i0_rsp_rdata,
              32'hA0 + 32'(k));
      end
    end
    @(negedge clk);
    idle();
    #1;
    check("t2_drained", 32'(arbt_active), 32'd0);

    // Full at two outstanding, one release re-enables issue next cycle
    @(negedge clk);
    idle(); i0_cmd_valid = 1; i1_cmd_valid = 1; o_cmd_ready = 1;
    #1 check("t3_first_i0", 32'(i0_cmd_ready), 32'd1);
    @(negedge clk);
    #1 check("t3_second_i1", 32'(i1_cmd_ready), 32'd1);
    @(negedge clk);
    o_rsp_valid = 1; i0_rsp_ready = 1;
    #1;
    check("t3_full_cmd_valid", 32'(o_cmd_valid), 32'd0);
    check("t3_full_i0_ready", 32'(i0_cmd_ready), 32'd0);
    check("t3_full_i1_ready", 32'(i1_cmd_ready), 32'd0);
    check("t3_pop_i0_rsp", 32'(i0_rsp_valid), 32'd1);
    check("t3_pop_ready", 32'(o_rsp_ready), 32'd1);
    @(negedge clk);
    o_rsp_valid = 0; i0_rsp_ready = 0;
    #1;
    check("t3_reissue_valid", 32'(o_cmd_valid), 32'd1);
    check("t3_reissue_i0", 32'(i0_cmd_ready), 32'd1);
    // Head is now the port-1 command
    @(negedge clk);
    idle(); o_rsp_valid = 1; i0_rsp_ready = 1; i1_rsp_ready = 1;
    #1;
    check("t3_head_i1", 32'(i1_rsp_valid), 32'd1);
    check("t3_head_not_i0", 32'(i0_rsp_valid), 32'd0);

    // Port-0 head stalled while a port-1 command waits behind it
    @(negedge clk);
    idle(); i1_cmd_valid = 1; o_cmd_ready = 1;
    #1 check("t4_i1_issue", 32'(i1_cmd_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle(); o_rsp_valid = 1; o_rsp_rdata = 32'h77; i0_rsp_ready = 0; i1_rsp_ready = 1;
      #1;
      check($sformatf("t4_stall_ready_%0d", k), 32'(o_rsp_ready), 32'd0);
      check($sformatf("t4_stall_i0_%0d", k), 32'(i0_rsp_valid), 32'd1);
      check($sformatf("t4_stall_i1_%0d", k), 32'(i1_rsp_valid), 32'd0);
    end
    @(negedge clk);
    i0_rsp_ready = 1;
    #1;
    check("t4_release_ready", 32'(o_rsp_ready), 32'd1);
    check("t4_release_i0", 32'(i0_rsp_valid), 32'd1);
    @(negedge clk);
    #1;
    check("t4_next_i1", 32'(i1_rsp_valid), 32'd1);
    check("t4_next_not_i0", 32'(i0_rsp_valid), 32'd0);
    @(negedge clk);
    idle();
    #1 check("t4_drained", 32'(arbt_active), 32'd0);

    // Push and pop together at one outstanding, across pointer wrap
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      idle();
      if (k < 10) begin
        i0_cmd_valid = !pat[k];
        i1_cmd_valid = pat[k];
      end
      o_cmd_ready = 1; i0_rsp_ready = 1; i1_rsp_ready = 1;
      o_rsp_valid = (k >= 1); o_rsp_rdata = 32'h5000 + 32'(k); o_rsp_usr = 3'(k);
      #1;
      if (k < 10) begin
        check($sformatf("t5_cmd_valid_%0d", k), 32'(o_cmd_valid), 32'd1);
        check($sformatf("t5_i0_ready_%0d", k), 32'(i0_cmd_ready), 32'(!pat[k]));
        check($sformatf("t5_i1_ready_%0d", k), 32'(i1_cmd_ready), 32'(pat[k]));
      end
      if (k >= 1) begin
        check($sformatf("t5_i0_rsp_%0d", k), 32'(i0_rsp_valid), 32'(!pat[k-1]));
        check($sformatf("t5_i1_rsp_%0d", k), 32'(i1_rsp_valid), 32'(pat[k-1]));
        check($sformatf("t5_usr_%0d", k), 32'(i1_rsp_usr), 32'(k % 8));
      end
    end
    @(negedge clk);
    idle();
    #1 check("t5_drained", 32'(arbt_active), 32'd0);

    // Reset with two outstanding and priority left on port 1
    @(negedge clk);
    idle(); i1_cmd_valid = 1; o_cmd_ready = 1;
    @(negedge clk);
    idle(); i0_cmd_valid = 1; o_cmd_ready = 1;
    @(negedge clk);
    idle(); i0_cmd_valid = 1; i1_cmd_valid = 1; o_cmd_ready = 1;
    #1 check("t6_full_block", 32'(o_cmd_valid), 32'd0);
    @(negedge clk);
    idle(); i0_rsp_ready = 1; i1_rsp_ready = 1;
    #1 check("t6_busy", 32'(arbt_active), 32'd1);
    rst_n = 0;
    #1;
    check("t6_rst_active", 32'(arbt_active), 32'd0);
    check("t6_rst_rsp_ready", 32'(o_rsp_ready), 32'd0);
    @(negedge clk);
    rst_n = 1; i0_cmd_valid = 1; i1_cmd_valid = 1; o_cmd_ready = 1;
    #1;
    check("t6_first_i0", 32'(i0_cmd_ready), 32'd1);
    check("t6_first_not_i1", 32'(i1_cmd_ready), 32'd0);
    @(negedge clk);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
